cache_mem_arbiter_rr: RTL and testbench



---
 rtl/cache_mem_arbiter_rr.sv | 115 +++++++++++
 tb/tb_cache_mem_arbiter_rr.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_rr.sv
// Round-robin arbiter from N cache miss ports onto one 1-cycle-latency read port.
// Routes the returned word to the granted cache and keeps saturating profiling counters.
module cache_mem_arbiter_rr #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DWIDTH     = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req_valid,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
    output logic [N_PORTS-1:0]            req_ready,
    output logic [N_PORTS*DWIDTH-1:0]     rsp_data,
    input  logic                          mem_ready,
    output logic                          mem_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DWIDTH-1:0]             mem_rdata,
    output logic [CNT_WIDTH-1:0]          grant_cnt,
    output logic [CNT_WIDTH-1:0]          stall_cnt
);

    localparam int PTR_W = $clog2(N_PORTS);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic                 rsp_pending_q, rsp_pending_d;
    logic [CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W:0]       scan_sum;
    logic [PTR_W-1:0]     scan_idx;

    // Cyclic scan starting at ptr; the first requester encountered wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_PORTS)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_PORTS);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!gnt_found && mem_ready && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_found && gnt_idx == PTR_W'(i)) begin
                req_ready[i] = 1'b1;
                mem_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        mem_en = gnt_found;
    end

    // A reset in the response cycle drops the word, hence the rst gate.
    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (rsp_pending_q && grant_q[i] && !rst) begin
                rsp_data[i*DWIDTH +: DWIDTH] = mem_rdata;
            end
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        rsp_pending_d = 1'b0;
        grant_cnt_d   = grant_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (gnt_found) begin
            ptr_d         = (gnt_idx == PTR_W'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
            grant_d       = req_ready;
            rsp_pending_d = 1'b1;
            if (grant_cnt_q != '1) begin
                grant_cnt_d = grant_cnt_q + 1'b1;
            end
        end
        if (|(req_valid & ~req_ready) && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            grant_q       <= '0;
            rsp_pending_q <= 1'b0;
            grant_cnt_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            rsp_pending_q <= rsp_pending_d;
            grant_cnt_q   <= grant_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cache_mem_arbiter_rr.sv
// Bench for cache_mem_arbiter_rr: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_cache_mem_arbiter_rr;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   rsp_data;
    logic              mem_ready;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;
    logic [CW-1:0]     grant_cnt;
    logic [CW-1:0]     stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    int m_ptr, m_port, m_gcnt, m_scnt;
    bit m_pend;

    cache_mem_arbiter_rr #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_data(rsp_data),
        .mem_ready(mem_ready), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr  = 0;
        m_port = 0;
        m_pend = 0;
        m_gcnt = 0;
        m_scnt = 0;
    endfunction

    // One clock cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input logic [N-1:0] v, input logic mr, input logic r,
                        input logic [N*AW-1:0] a, input logic [DW-1:0] d,
                        output int g);
        logic [N-1:0]    e_rdy;
        logic [AW-1:0]   e_addr;
        logic [N*DW-1:0] e_rsp;
        @(negedge clk);
        req_valid = v;
        mem_ready = mr;
        rst       = r;
        req_addr  = a;
        mem_rdata = d;
        #1;
        g = -1;
        if (mr) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        e_rdy  = '0;
        e_addr = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_addr   = a[g*AW +: AW];
        end
        e_rsp = '0;
        if (m_pend && !r) e_rsp[m_port*DW +: DW] = d;
        chk("req_ready", req_ready, e_rdy);
        chk("mem_en",    mem_en,    g >= 0);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("rsp_data",  rsp_data,  e_rsp);
        chk("grant_cnt", grant_cnt, m_gcnt);
        chk("stall_cnt", stall_cnt, m_scnt);
        if (r) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_ptr  = (g + 1) % N;
                m_pend = 1;
                m_port = g;
                if (m_gcnt < CMAX) m_gcnt++;
            end else begin
                m_pend = 0;
            end
            if ((v & ~e_rdy) != 0 && m_scnt < CMAX) m_scnt++;
        end
    endtask

    function automatic logic [N*AW-1:0] raddr();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        int g;
        step('0, 1'b1, 1'b1, raddr(), DW'($urandom), g);
    endtask

    initial begin
        int g;
        logic [N*AW-1:0] a;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        mem_ready = 1'b1;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        model_reset();

        // Reset state
        step('0, 1'b1, 1'b0, raddr(), 16'h1234, g);
        chk("rst_grant", grant_cnt, 0);

        // Single request from port 2
        a = raddr();
        a[2*AW +: AW] = 16'h0123;
        step(4'b0100, 1'b1, 1'b0, a, DW'($urandom), g);
        chk("single_gnt", g, 2);
        chk("single_addr", mem_addr, 16'h0123);
        step('0, 1'b1, 1'b0, raddr(), 16'hBEEF, g);
        chk("single_rsp", rsp_data, 64'hBEEF << (2*DW));
        chk("single_cnt", grant_cnt, 1);

        // All ports continuously from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b1, 1'b0, raddr(), DW'($urandom), g);
            chk("rr_order", g, k % N);
        end
        step('0, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("rr_stall", stall_cnt, 5);

        // mem_ready held low
        do_reset();
        repeat (5) step(4'b0010, 1'b0, 1'b0, raddr(), DW'($urandom), g);
        step(4'b0010, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("mr_gnt", g, 1);
        chk("mr_stall", stall_cnt, 5);

        // Pointer wrap
        do_reset();
        step(4'b0100, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        step(4'b1001, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("wrap_first", g, 3);
        step(4'b0001, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("wrap_second", g, 0);
        step(4'b1111, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("wrap_ptr", g, 1);

        // Reset in the response cycle
        do_reset();
        step(4'b0010, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        step('0, 1'b1, 1'b1, raddr(), 16'hA5A5, g);
        chk("rst_drop", rsp_data, 0);
        step(4'b1111, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("rst_ptr", g, 0);
        chk("rst_cnt", grant_cnt, 0);

        // Counter saturation
        do_reset();
        repeat (20) step(4'b1111, 1'b1, 1'b0, raddr(), DW'($urandom), g);
        chk("sat_grant", grant_cnt, CMAX);
        chk("sat_stall", stall_cnt, CMAX);

        // Random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(N'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0, raddr(), DW'($urandom), g);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
